// File: rtl/tron_pkg.sv
// Shared types and helpers for the tron input/game-phase logic.
// The PAUSE state exists only when PAUSE_EN is defined.
package tron_pkg;

    localparam logic [9:0] LAST_ROW = 10'd599;
    localparam logic [9:0] LAST_COL = 10'd799;

    typedef enum logic [2:0] {
        DIR_UP    = 3'b000,
        DIR_DOWN  = 3'b001,
        DIR_LEFT  = 3'b010,
        DIR_RIGHT = 3'b011,
        DIR_STOP  = 3'b100
    } player_dir_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_RUN       = 3'd2,
        ST_OVER      = 3'd3
`ifdef PAUSE_EN
        , ST_PAUSE   = 3'd4
`endif
    } game_state_t;

    // STOP has no opposite, so nothing is rejected while a player is stopped.
    function automatic player_dir_t opposite(input player_dir_t d);
        case (d)
            DIR_UP:    return DIR_DOWN;
            DIR_DOWN:  return DIR_UP;
            DIR_LEFT:  return DIR_RIGHT;
            DIR_RIGHT: return DIR_LEFT;
            default:   return DIR_STOP;
        endcase
    endfunction

endpackage

// File: rtl/player_input_ctrl_btn_debounce.sv
// Two-flop synchronizer plus stable-level debounce for one raw button;
// emits a single-cycle press pulse on each accepted rising level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic [CW-1:0] cnt_reg;
    logic          level_reg;
    logic          press_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            press_reg <= 1'b0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            press_reg <= 1'b0;
            // Counter only runs while the synchronized sample disagrees with the accepted level.
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                cnt_reg   <= '0;
                level_reg <= sync2_reg;
                press_reg <= sync2_reg;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

    assign level = level_reg;
    assign press = press_reg;

endmodule

// File: rtl/player_input_ctrl.sv
// Button conditioning, reversal filtering and game-phase FSM for both players.
// Optional PAUSE state enabled by defining PAUSE_EN.
module player_input_ctrl
    import tron_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = 500000,
    parameter int COUNTDOWN_FRAMES = 120
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] row,
    input  logic [9:0] col,
    input  logic [3:0] p1_btn,
    input  logic [3:0] p2_btn,
    input  logic       start_btn,
    input  logic       crash,
    output logic [2:0] p1_info,
    output logic [2:0] p2_info,
    output logic       dflt,
    output logic [2:0] game_state
);

    localparam int CD_W = (COUNTDOWN_FRAMES > 1) ? $clog2(COUNTDOWN_FRAMES) : 1;
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COUNTDOWN_FRAMES - 1);

    logic [8:0] raw_all;
    logic [8:0] press_all;
    logic [8:0] unused_level;

    assign raw_all = {start_btn, p2_btn, p1_btn};

    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_db (
                .clock(clock),
                .reset(reset),
                .raw  (raw_all[gi]),
                .level(unused_level[gi]),
                .press(press_all[gi])
            );
        end
    endgenerate

    // Bit i of a press vector maps to direction code i; lower index has priority.
    function automatic player_dir_t pick(input logic [3:0] presses,
                                         input player_dir_t committed,
                                         input player_dir_t current);
        player_dir_t r;
        r = current;
        for (int i = 3; i >= 0; i--) begin
            if (presses[i] && (player_dir_t'(3'(i)) != opposite(committed)))
                r = player_dir_t'(3'(i));
        end
        return r;
    endfunction

    game_state_t     state_reg;
    logic [CD_W-1:0] cd_reg;
    player_dir_t     p1_pend_reg, p2_pend_reg;
    player_dir_t     p1_comm_reg, p2_comm_reg;
    player_dir_t     p1_pend_next, p2_pend_next;
    player_dir_t     p1_info_reg, p2_info_reg;
    logic            dflt_reg;
    logic            start_pend_reg;
    logic            crash_pend_reg;
    logic            tick;

    assign tick = (row == LAST_ROW) && (col == LAST_COL);

    always_comb begin
        p1_pend_next = pick(press_all[3:0], p1_comm_reg, p1_pend_reg);
        p2_pend_next = pick(press_all[7:4], p2_comm_reg, p2_pend_reg);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            cd_reg         <= '0;
            p1_pend_reg    <= DIR_STOP;
            p2_pend_reg    <= DIR_STOP;
            p1_comm_reg    <= DIR_STOP;
            p2_comm_reg    <= DIR_STOP;
            p1_info_reg    <= DIR_STOP;
            p2_info_reg    <= DIR_STOP;
            dflt_reg       <= 1'b1;
            start_pend_reg <= 1'b0;
            crash_pend_reg <= 1'b0;
        end else begin
            p1_pend_reg    <= p1_pend_next;
            p2_pend_reg    <= p2_pend_next;
            start_pend_reg <= start_pend_reg | press_all[8];
            crash_pend_reg <= crash_pend_reg | crash;
            if (tick) begin
                // Events arriving on the tick cycle itself survive to the next frame.
                start_pend_reg <= press_all[8];
                crash_pend_reg <= crash;
                case (state_reg)
                    ST_IDLE: begin
                        dflt_reg    <= 1'b1;
                        p1_info_reg <= DIR_STOP;
                        p2_info_reg <= DIR_STOP;
                        if (start_pend_reg) begin
                            state_reg <= ST_COUNTDOWN;
                            cd_reg    <= CD_LOAD;
                        end
                    end
                    ST_COUNTDOWN: begin
                        if (cd_reg == '0) begin
                            state_reg   <= ST_RUN;
                            p1_comm_reg <= DIR_UP;
                            p2_comm_reg <= DIR_DOWN;
                            p1_pend_reg <= DIR_UP;
                            p2_pend_reg <= DIR_DOWN;
                            p1_info_reg <= DIR_UP;
                            p2_info_reg <= DIR_DOWN;
                            dflt_reg    <= 1'b0;
                        end else begin
                            cd_reg <= cd_reg - CD_W'(1);
                        end
                    end
                    ST_RUN: begin
                        dflt_reg <= 1'b0;
                        if (crash_pend_reg) begin
                            state_reg   <= ST_OVER;
                            p1_info_reg <= DIR_STOP;
                            p2_info_reg <= DIR_STOP;
`ifdef PAUSE_EN
                        end else if (start_pend_reg) begin
                            state_reg   <= ST_PAUSE;
                            p1_info_reg <= DIR_STOP;
                            p2_info_reg <= DIR_STOP;
`endif
                        end else begin
                            p1_comm_reg <= p1_pend_reg;
                            p2_comm_reg <= p2_pend_reg;
                            p1_info_reg <= p1_pend_reg;
                            p2_info_reg <= p2_pend_reg;
                        end
                    end
                    ST_OVER: begin
                        p1_info_reg <= DIR_STOP;
                        p2_info_reg <= DIR_STOP;
                        if (start_pend_reg) begin
                            state_reg <= ST_IDLE;
                            dflt_reg  <= 1'b1;
                        end
                    end
`ifdef PAUSE_EN
                    ST_PAUSE: begin
                        if (crash_pend_reg) begin
                            state_reg <= ST_OVER;
                        end else if (start_pend_reg) begin
                            state_reg   <= ST_RUN;
                            p1_info_reg <= p1_comm_reg;
                            p2_info_reg <= p2_comm_reg;
                        end
                    end
`endif
                    default: begin
                        state_reg   <= ST_IDLE;
                        dflt_reg    <= 1'b1;
                        p1_info_reg <= DIR_STOP;
                        p2_info_reg <= DIR_STOP;
                    end
                endcase
            end
        end
    end

    assign p1_info    = p1_info_reg;
    assign p2_info    = p2_info_reg;
    assign dflt       = dflt_reg;
    assign game_state = state_reg;

endmodule

// File: doc/player_input_ctrl.md
# player_input_ctrl

Converts raw button inputs for both players into the per-frame 3-bit direction codes (`p1_info`, `p2_info`) and the `dflt` position-reset flag consumed by `draw_object`. It synchronizes and debounces every button, rejects 180° reversals, and runs the game-phase state machine (idle, countdown, run, over). All outputs change only at the frame boundary, so the drawing stage sees stable values for a whole frame.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: stable-level cycles a button needs before it is accepted (10 ms at 50 MHz).
- `COUNTDOWN_FRAMES`, default 120: frames spent in COUNTDOWN before RUN.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `row`  in  10  current VGA row (0..599).
- `col`  in  10  current VGA column (0..799).
- `p1_btn`  in  4  raw, asynchronous P1 buttons, bits [3:0] = {RIGHT, LEFT, DOWN, UP}.
- `p2_btn`  in  4  raw P2 buttons, same bit order.
- `start_btn`  in  1  raw start/pause button.
- `crash`  in  1  collision pulse from the collision stage; may be asserted in any cycle.
- `p1_info`  out  3  committed P1 direction.
- `p2_info`  out  3  committed P2 direction.
- `dflt`  out  1  1 = `draw_object` forces players to their start positions.
- `game_state`  out  3  current FSM state.

## Operation
- Direction codes: UP=000, DOWN=001, LEFT=010, RIGHT=011, STOP=100. Opposite pairs: UP/DOWN and LEFT/RIGHT.
- Button conditioning: each of the 9 raw inputs passes through a 2-flop synchronizer, then a debounce counter.
  - The debounced level changes only after `DEBOUNCE_CYCLES` consecutive equal synchronized samples.
  - A rising edge of the debounced level produces a 1-cycle press pulse.
- Pending direction, one per player:
  - On a press pulse, `pending` <= the pressed direction, unless that direction is opposite to the player's committed direction; a reversal press is dropped.
  - If several presses arrive in the same cycle, priority is UP > DOWN > LEFT > RIGHT. The highest-priority non-reversal press wins.
- Frame tick: `tick` = (`row` == 599) && (`col` == 799), the same condition `draw_object` uses.
- Event latches:
  - `start_pend` is set by a start press pulse.
  - `crash_pend` is set whenever `crash` = 1.
  - Both are cleared on the cycle they are consumed at a tick.
- FSM (game_state encoding: IDLE=0, COUNTDOWN=1, RUN=2, OVER=3, PAUSE=4). All transitions happen only on `tick`.
  - IDLE: `dflt`=1, both info=STOP. If `start_pend` → COUNTDOWN; countdown counter loaded with `COUNTDOWN_FRAMES`-1.
  - COUNTDOWN: `dflt`=1, info=STOP. Counter decrements each tick. At 0 → RUN; committed and pending initialize to P1=UP, P2=DOWN.
  - RUN: `dflt`=0, info=committed.
    - Each tick: committed <= pending.
    - If `crash_pend` → OVER. Crash takes priority over a simultaneous start.
  - OVER: `dflt`=0, info=STOP, so the trails freeze. If `start_pend` → IDLE.
- Presses arriving outside RUN still pass through debouncing, but pending is overwritten when COUNTDOWN exits.

## Timing
- Reset values: state=IDLE, `p1_info`=`p2_info`=100, `dflt`=1, `game_state`=000.
  - All counters, latches, synchronizers and debounced levels are cleared to 0.
  - Pending and committed are STOP.
- All outputs are registered. They update on the clock edge at which `tick` is sampled high and are held for the following 480000 cycles (one full frame).
- Button latency from raw edge to pending: 2 synchronizer cycles + `DEBOUNCE_CYCLES` + 1 edge-detect cycle. Reaching the outputs additionally waits for the next tick.
- A crash arriving in the same cycle as the tick is latched and acted on at the following tick; it is not lost.
- Reset asserted mid-game returns to IDLE on the next edge, regardless of `tick`.

## Configuration
- `PAUSE_EN` defined:
  - A start press consumed in RUN → PAUSE (info=STOP, `dflt`=0).
  - A start press in PAUSE → RUN. Committed and pending are preserved, and a reversal check against committed still applies.
  - `crash_pend` in PAUSE → OVER.
- `PAUSE_EN` undefined: PAUSE state and encoding 4 do not exist, and start presses in RUN are discarded (latch cleared at tick).

## Structure
- `tron_pkg` holds:
  - `player_dir_t` enum (the five codes above).
  - `game_state_t` enum.
  - `LAST_ROW`=599 and `LAST_COL`=799.
  - An `opposite()` function.
- Sub-module `btn_debounce` (parameter `DEBOUNCE_CYCLES`; ports `clock`, `reset`, `raw`, `level`, `press`): one instance per button, 9 in total.

## Test plan
Simulate with `DEBOUNCE_CYCLES`=4 and `COUNTDOWN_FRAMES`=2, and drive `row`/`col` from a frame counter.
1. Reset, no input → `p1_info`=`p2_info`=100, `dflt`=1 and `game_state`=0 for 3 frames.
2. Pulse `start_btn` 10 cycles → COUNTDOWN at the next tick, RUN 2 ticks later with `dflt`=0, `p1_info`=000, `p2_info`=001.
3. In RUN, press P1 DOWN (reversal) → `p1_info` stays 000. Press P1 LEFT → 010 after the next tick.
4. Button glitch shorter than 4 stable cycles → no change to pending or outputs.
5. Press P2 UP and RIGHT in the same cycle → `p2_info`=011. UP is rejected as a reversal of DOWN, so RIGHT is applied.
6. `crash` 1-cycle pulse coincident with `tick` → still RUN at that tick; OVER with both info=100 at the next tick. With `PAUSE_EN`: start in RUN → `game_state`=4, info=100; start again → RUN with prior directions.
